argmax_sched: RTL and testbench
===============================

Name: argmax_sched

Overview:
- Controller that sequences the shared 9-class argmax engine at the classifier tail.
- Collects FC-layer logits from a valid/ready stream into a register bank and drives the bank onto the argmax data inputs.
- Clears the argmax engine with a local reset pulse, because its done flag is sticky; then starts it, waits for done (with timeout) and returns the winning class over a valid/ready result handshake.

Parameters:
- NUM_CLASSES, 9, number of logits per frame; must equal the argmax engine width.
- DATA_W, 32, signed logit width.
- IDX_W, 4, class index width; must satisfy 2^IDX_W > NUM_CLASSES.
- TIMEOUT_CYC, 64, maximum cycles spent in WAIT before an error result.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- s_valid  in  1  logit beat valid
- s_ready  out  1  logit beat accepted
- s_data  in  DATA_W  signed logit
- s_last  in  1  final logit of frame
- am_resetn  out  1  synchronous active-low clear to argmax engine
- am_start  out  1  argmax start pulse
- am_data  out  NUM_CLASSES*DATA_W  logit bank, class 0 in LSBs
- am_done  in  1  argmax done (sticky)
- am_index  in  IDX_W  argmax winner
- res_valid  out  1  result valid
- res_ready  in  1  result consumed
- res_class  out  IDX_W  winning class
- res_error  out  1  frame length or timeout error
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE; beat count=0; timeout count=0.
  - Logit bank cleared to 0; am_start=0; am_resetn=0 while resetn=0.
  - res_valid=0, res_class=0, res_error=0, busy=0, s_ready=0.
- States: IDLE, LOAD, CLEAR, START, WAIT, RESULT.
- IDLE:
  - s_ready=1.
  - An accepted beat writes bank[0], sets count=1 and goes to LOAD. If s_last is set on that beat, it goes to RESULT with error instead (see short frame).
- LOAD:
  - s_ready=1. Each accepted beat writes bank[count] and increments count.
  - s_last with count+1==NUM_CLASSES → CLEAR.
  - s_last with count+1<NUM_CLASSES (short frame) → RESULT, res_error=1, res_class=0. The argmax engine is not run.
  - Beats arriving at count==NUM_CLASSES are accepted and discarded; an error flag is latched.
  - s_last when the overflow flag is set → RESULT, res_error=1, res_class=0.
- CLEAR: am_resetn=0 for exactly one cycle → START.
- START: am_start=1 for exactly one cycle → WAIT; timeout count cleared.
- WAIT:
  - am_done=1 → latch am_index into res_class, res_error=0 → RESULT.
  - If am_done is not seen, the timeout counter increments each cycle. When it reaches TIMEOUT_CYC-1 → RESULT, res_error=1, res_class=0.
  - am_done is ignored in every other state.
- RESULT:
  - res_valid=1; res_class and res_error held stable.
  - res_valid && res_ready → IDLE, res_valid=0, count=0. Bank contents are retained until overwritten.
- s_ready=0 in CLEAR, START, WAIT and RESULT (back-pressure).
- am_resetn=1 except in CLEAR and during reset.
- am_data is a continuous view of the bank.
- Nominal latency: 9 argmax iterations plus overhead. From the s_last acceptance edge to res_valid is 13 cycles.
- Reset mid-operation returns the block to IDLE and drives am_resetn low, so the engine is cleared too. No partial result is emitted.
- s_valid with s_ready=0 has no effect; the upstream source must hold its data stable.

Optional Feature:
- Macro: ARGMAX_SCORE_OUT_EN.
- Defined:
  - Adds output res_score (DATA_W, signed) = bank[am_index], latched together with res_class.
  - res_score=0 on an error result or reset.
- Undefined: the port and its register do not exist.

Decomposition:
- Package argmax_sched_pkg: state enum typedef, default NUM_CLASSES / DATA_W / IDX_W localparams, and error-code constants.
- One sub-module is natural: logit_bank (write-indexed register file with flattened read view and clear).
- The argmax engine is instantiated by the parent, not inside this block.

Test Plan:
- Frame 5,-3,17,2,0,-8,9,17,1 → one am_resetn low pulse, one am_start pulse, res_class=2, res_error=0, res_valid 13 cycles after s_last; then res_ready=1 → IDLE.
- Short frame of 4 beats, s_last on the 4th → res_error=1, res_class=0, am_start never asserted.
- Eleven beats, s_last on the 11th → beats 10 and 11 discarded, res_error=1, no argmax run.
- Model am_done tied to 0 → res_error=1 after 64 WAIT cycles; am_done asserted later is ignored.
- res_ready held low 20 cycles in RESULT with s_valid=1 → s_ready=0 throughout, res_class stable; back-to-back second frame all -1 except class 8=0 → res_class=8.
- resetn pulsed low while in WAIT → all outputs at reset values, am_resetn=0; a fresh frame afterwards completes normally.

Source files
------------

// File: rtl/argmax_sched_pkg.sv
// Shared types and default sizing for the argmax scheduler and its logit bank.
package argmax_sched_pkg;

    localparam int NUM_CLASSES_DEF = 9;
    localparam int DATA_W_DEF      = 32;
    localparam int IDX_W_DEF       = 4;
    localparam int TIMEOUT_CYC_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR,
        ST_START,
        ST_WAIT,
        ST_RESULT
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LENGTH  = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_code_t;

endpackage

// File: rtl/argmax_sched_logit_bank.sv
// Write-indexed logit register file with a flattened read view (entry 0 in the LSBs).
module argmax_sched_logit_bank
    import argmax_sched_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int IDX_W       = IDX_W_DEF
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          wr_en,
    input  logic [IDX_W-1:0]              wr_idx,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [NUM_CLASSES*DATA_W-1:0] rd_flat
);

    generate
        for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_entry
            logic [DATA_W-1:0] entry_q;
            logic [DATA_W-1:0] entry_d;

            always_comb begin
                entry_d = entry_q;
                if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    entry_d = wr_data;
                end
            end

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    entry_q <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign rd_flat[gi*DATA_W +: DATA_W] = entry_q;
        end
    endgenerate

endmodule

// File: rtl/argmax_sched.sv
// Collects one frame of logits, runs the shared argmax engine and returns the winner.
// Defining ARGMAX_SCORE_OUT_EN adds res_score, the winning logit value.
module argmax_sched
    import argmax_sched_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int IDX_W       = IDX_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_last,
    output logic                          am_resetn,
    output logic                          am_start,
    output logic [NUM_CLASSES*DATA_W-1:0] am_data,
    input  logic                          am_done,
    input  logic [IDX_W-1:0]              am_index,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [IDX_W-1:0]              res_class,
    output logic                          res_error,
`ifdef ARGMAX_SCORE_OUT_EN
    output logic [DATA_W-1:0]             res_score,
`endif
    output logic                          busy
);

    localparam int TO_W = $clog2(TIMEOUT_CYC);
    localparam logic [IDX_W-1:0] FULL_CNT = IDX_W'(NUM_CLASSES);
    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NUM_CLASSES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [IDX_W-1:0]  class_q, class_d;
    err_code_t         err_q, err_d;
    logic              wr_en;
    logic              clear_pulse;
    logic              start_pulse;

`ifdef ARGMAX_SCORE_OUT_EN
    logic [DATA_W-1:0] score_q, score_d, sel_score;

    always_comb begin
        sel_score = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (am_index == IDX_W'(i)) begin
                sel_score = am_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign res_score = score_q;
`endif

    argmax_sched_logit_bank #(
        .NUM_CLASSES (NUM_CLASSES),
        .DATA_W      (DATA_W),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (wr_en),
        .wr_idx  (count_q),
        .wr_data (s_data),
        .rd_flat (am_data)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        to_cnt_d    = to_cnt_q;
        class_d     = class_q;
        err_d       = err_q;
`ifdef ARGMAX_SCORE_OUT_EN
        score_d     = score_q;
`endif
        s_ready     = 1'b0;
        wr_en       = 1'b0;
        clear_pulse = 1'b0;
        start_pulse = 1'b0;
        res_valid   = 1'b0;

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                s_ready = resetn;
                if (s_valid && s_ready) begin
                    state_d = ST_LOAD;
                    // Beats past a full bank are swallowed but poison the frame.
                    if (count_q == FULL_CNT) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        count_d = count_q + IDX_W'(1);
                    end
                    if (s_last) begin
                        if (!ovf_q && (count_q == LAST_CNT)) begin
                            state_d = ST_CLEAR;
                        end else begin
                            state_d = ST_RESULT;
                            class_d = '0;
                            err_d   = ERR_LENGTH;
`ifdef ARGMAX_SCORE_OUT_EN
                            score_d = '0;
`endif
                        end
                    end
                end
            end
            ST_CLEAR: begin
                // The engine's done flag is sticky, so it is cleared before every run.
                clear_pulse = 1'b1;
                state_d     = ST_START;
            end
            ST_START: begin
                start_pulse = 1'b1;
                to_cnt_d    = '0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (am_done) begin
                    class_d = am_index;
                    err_d   = ERR_NONE;
`ifdef ARGMAX_SCORE_OUT_EN
                    score_d = sel_score;
`endif
                    state_d = ST_RESULT;
                end else if (to_cnt_q == TO_LAST) begin
                    class_d = '0;
                    err_d   = ERR_TIMEOUT;
`ifdef ARGMAX_SCORE_OUT_EN
                    score_d = '0;
`endif
                    state_d = ST_RESULT;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            to_cnt_q <= '0;
            class_q  <= '0;
            err_q    <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            to_cnt_q <= to_cnt_d;
            class_q  <= class_d;
            err_q    <= err_d;
        end
    end

    assign am_resetn = resetn & ~clear_pulse;
    assign am_start  = resetn & start_pulse;
    assign res_class = class_q;
    assign res_error = (err_q != ERR_NONE);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_argmax_sched.sv
// Bench for argmax_sched: directed frames, a simple argmax engine stand-in and a per-cycle frame model.
`timescale 1ns/1ps
module tb_argmax_sched;

    localparam int NC      = 9;
    localparam int DW      = 32;
    localparam int IW      = 4;
    localparam int TO      = 64;
    localparam int ENG_LAT = NC + 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          res_ready = 1'b1;
    logic          s_ready, am_resetn, am_start, am_done, res_valid, res_error, busy;
    logic [NC*DW-1:0] am_data;
    logic [IW-1:0] am_index, res_class;
`ifdef ARGMAX_SCORE_OUT_EN
    logic [DW-1:0] res_score;
`endif

    always #5 clk = ~clk;

    argmax_sched dut (
        .clk       (clk),
        .resetn    (resetn),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .am_resetn (am_resetn),
        .am_start  (am_start),
        .am_data   (am_data),
        .am_done   (am_done),
        .am_index  (am_index),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_class (res_class),
        .res_error (res_error),
`ifdef ARGMAX_SCORE_OUT_EN
        .res_score (res_score),
`endif
        .busy      (busy)
    );

    // ---------------- argmax engine stand-in ----------------
    logic          eng_done = 1'b0;
    logic [IW-1:0] eng_idx = '0;
    int            eng_cnt = 0;
    logic          eng_start_s = 1'b0, eng_clr_s = 1'b0;
    logic [IW-1:0] eng_idx_s = '0;
    logic          engine_dead = 1'b0, force_done = 1'b0;

    assign am_done  = force_done | (eng_done & ~engine_dead);
    assign am_index = eng_idx;

    function automatic int flat_argmax(input logic [NC*DW-1:0] f);
        int best = 0;
        for (int i = 1; i < NC; i++)
            if ($signed(f[i*DW +: DW]) > $signed(f[best*DW +: DW])) best = i;
        return best;
    endfunction

    int   cyc = 0;
    logic in_reset = 1'b0;
    logic started = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        in_reset <= !resetn;
        if (!resetn) started <= 1'b1;
        if (eng_clr_s) begin
            eng_done <= 1'b0;
            eng_cnt  <= 0;
        end else if (eng_start_s) begin
            eng_idx <= eng_idx_s;
            eng_cnt <= 1;
        end else if (eng_cnt == ENG_LAT) begin
            eng_done <= 1'b1;
            eng_cnt  <= 0;
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt + 1;
        end
    end

    // ---------------- frame model and checker ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    logic signed [DW-1:0] bank_m [NC];
    int   beats_m = 0;
    bit   pending = 0;
    int   acc_edge = 0;
    int   exp_lat = 0, exp_class = 0, exp_starts = 0, exp_clears = 0;
    logic exp_err = 1'b0;
    logic [DW-1:0] exp_score = '0;
    int   starts_seen = 0, clears_seen = 0;
    bit   seen_valid = 0;
    int   last_lat = 0, last_starts = 0;
    logic [IW-1:0] last_class = '0;
    logic last_err = 1'b0;
    logic [NC*DW-1:0] exp_flat;

    // Winner = lowest class index holding the maximum logit.
    function automatic int model_argmax();
        logic signed [DW-1:0] mx = bank_m[0];
        for (int i = 1; i < NC; i++) if (bank_m[i] > mx) mx = bank_m[i];
        for (int i = 0; i < NC; i++) if (bank_m[i] == mx) return i;
        return 0;
    endfunction

    initial for (int i = 0; i < NC; i++) bank_m[i] = '0;

    always @(negedge clk) begin
        eng_start_s <= am_start;
        eng_clr_s   <= !am_resetn;
        eng_idx_s   <= IW'(flat_argmax(am_data));
        if (started) begin
            if (in_reset) begin
                for (int i = 0; i < NC; i++) bank_m[i] = '0;
                beats_m = 0;
                pending = 0;
            end
            for (int i = 0; i < NC; i++) exp_flat[i*DW +: DW] = bank_m[i];
            checks++;
            if (am_data !== exp_flat) begin
                errors++;
                $display("FAIL am_data cycle=%0d got=%h want=%h", cyc, am_data, exp_flat);
            end
            if (!resetn || in_reset) begin
                if (!resetn) begin
                    chk("rst_am_resetn", am_resetn, 0);
                    chk("rst_s_ready", s_ready, 0);
                    chk("rst_am_start", am_start, 0);
                end
                if (in_reset) begin
                    chk("rst_res_valid", res_valid, 0);
                    chk("rst_res_class", res_class, 0);
                    chk("rst_res_error", res_error, 0);
                    chk("rst_busy", busy, 0);
                end
            end else if (!pending) begin
                chk("idle_res_valid", res_valid, 0);
                chk("idle_s_ready", s_ready, 1);
                chk("idle_busy", busy, 64'(beats_m != 0));
                chk("idle_am_resetn", am_resetn, 1);
                chk("idle_am_start", am_start, 0);
            end else begin
                int age;
                chk("run_s_ready", s_ready, 0);
                chk("run_busy", busy, 1);
                if (am_start) starts_seen++;
                if (!am_resetn) clears_seen++;
                age = cyc - acc_edge;
                if (res_valid && !seen_valid) begin
                    seen_valid  = 1;
                    last_lat    = age;
                    last_class  = res_class;
                    last_err    = res_error;
                    last_starts = starts_seen;
                end
                if (age < exp_lat) begin
                    chk("early_res_valid", res_valid, 0);
                end else begin
                    chk("res_valid", res_valid, 1);
                    chk("res_class", res_class, 64'(exp_class));
                    chk("res_error", res_error, 64'(exp_err));
`ifdef ARGMAX_SCORE_OUT_EN
                    chk("res_score", res_score, 64'(exp_score));
`endif
                    if (age == exp_lat) begin
                        chk("am_start_pulses", 64'(starts_seen), 64'(exp_starts));
                        chk("am_clear_pulses", 64'(clears_seen), 64'(exp_clears));
                    end
                end
            end
            // Advance the model to the state after the coming edge.
            if (resetn) begin
                if (!pending && s_valid) begin
                    if (beats_m < NC) bank_m[beats_m] = s_data;
                    beats_m++;
                    if (s_last) begin
                        pending     = 1;
                        acc_edge    = cyc + 1;
                        seen_valid  = 0;
                        starts_seen = 0;
                        clears_seen = 0;
                        if (beats_m == NC) begin
                            exp_starts = 1;
                            exp_clears = 1;
                            if (engine_dead) begin
                                exp_err = 1; exp_class = 0; exp_score = '0; exp_lat = 2 + TO;
                            end else begin
                                exp_err = 0; exp_class = model_argmax();
                                exp_score = bank_m[exp_class]; exp_lat = 3 + ENG_LAT;
                            end
                        end else begin
                            exp_starts = 0; exp_clears = 0;
                            exp_err = 1; exp_class = 0; exp_score = '0; exp_lat = 0;
                        end
                    end
                end else if (pending && res_valid && res_ready) begin
                    pending = 0;
                    beats_m = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int fr[$];

    task automatic drive_beat(input int d, input bit l);
        int waited = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        forever begin
            @(negedge clk);
            if (s_ready && resetn) break;
            waited++;
            if (waited > 300) begin
                checks++; errors++;
                $display("FAIL beat_accept_timeout cycle=%0d got=no_accept want=accept", cyc);
                break;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < fr.size(); i++) drive_beat(fr[i], i == fr.size() - 1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!seen_valid && n < 400) begin @(negedge clk); n++; end
        if (!seen_valid) begin
            checks++; errors++;
            $display("FAIL wait_valid_timeout got=no_res_valid want=res_valid");
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (pending && n < 400) begin @(negedge clk); n++; end
        if (pending) begin
            checks++; errors++;
            $display("FAIL wait_done_timeout got=pending want=idle");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Nominal frame: tie between classes 2 and 7 resolves to 2.
        fr = '{5, -3, 17, 2, 0, -8, 9, 17, 1};
        send_frame();
        wait_done();
        chk("t1_class", last_class, 2);
        chk("t1_error", last_err, 0);
        chk("t1_latency", 64'(last_lat), 13);
        chk("t1_starts", 64'(last_starts), 1);
        $display("frame1 class=%0d err=%0d lat=%0d", last_class, last_err, last_lat);

        // Short frame.
        fr = '{4, 3, 2, 1};
        send_frame();
        wait_done();
        chk("t2_error", last_err, 1);
        chk("t2_class", last_class, 0);
        chk("t2_starts", 64'(last_starts), 0);
        chk("t2_latency", 64'(last_lat), 0);
        $display("short frame err=%0d class=%0d", last_err, last_class);

        // Eleven-beat frame; beats 10 and 11 must be discarded.
        fr = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 100, 200};
        send_frame();
        wait_done();
        chk("t3_error", last_err, 1);
        chk("t3_starts", 64'(last_starts), 0);
        $display("long frame err=%0d starts=%0d", last_err, last_starts);

        // Dead engine: timeout, then a late done while parked in RESULT.
        engine_dead = 1'b1;
        res_ready   = 1'b0;
        fr = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        send_frame();
        wait_valid();
        force_done = 1'b1;
        repeat (5) @(posedge clk);
        #1 force_done = 1'b0;
        res_ready = 1'b1;
        wait_done();
        engine_dead = 1'b0;
        chk("t4_error", last_err, 1);
        chk("t4_class", last_class, 0);
        chk("t4_latency", 64'(last_lat), 66);
        $display("timeout frame err=%0d lat=%0d", last_err, last_lat);

        // Back-pressure in RESULT with a waiting beat, then a back-to-back frame.
        res_ready = 1'b0;
        fr = '{10, 20, 30, 40, 50, 60, 70, 80, -5};
        send_frame();
        wait_valid();
        chk("t5a_class", last_class, 7);
        s_valid = 1'b1;
        s_data  = '1;
        s_last  = 1'b0;
        repeat (20) @(posedge clk);
        #1 res_ready = 1'b1;
        fr = '{-1, -1, -1, -1, -1, -1, -1, -1, 0};
        send_frame();
        wait_done();
        chk("t5b_class", last_class, 8);
        chk("t5b_error", last_err, 0);
        $display("backpressure frames class=7 then class=%0d", last_class);

        // Reset while waiting on the engine, then a clean frame.
        fr = '{5, -3, 17, 2, 0, -8, 9, 17, 1};
        send_frame();
        repeat (5) @(posedge clk);
        #1 resetn = 1'b0;
        @(negedge clk);
        chk("t6_am_resetn_low", am_resetn, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_res_valid", res_valid, 0);
        @(posedge clk); #1 resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send_frame();
        wait_done();
        chk("t6_class", last_class, 2);
        chk("t6_latency", 64'(last_lat), 13);
        $display("post-reset frame class=%0d lat=%0d", last_class, last_lat);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
